stack_ctrl: RTL and testbench

Multi-cycle sequencer for PUSH/POP/CALL/RET. Drives the register bank's SP read/write port, second read port and write port, plus a single-port data-memory request/ready handshake. Sits between the instruction decoder (start/op) and regbank/data memory. Enforces stack bounds and reports errors.

---
 rtl/stack_ctrl_pkg.sv | 34 +++
 rtl/stack_addr_calc.sv | 37 +++
 rtl/stack_ctrl.sv | 157 +++++++++++++++
 tb/tb_stack_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared encodings and stack geometry for the PUSH/POP/CALL/RET sequencer
// and the decoder-side address/bounds calculator.
package stack_ctrl_pkg;

  localparam logic [31:0] STACK_BASE_DEF  = 32'h0000_1000;
  localparam logic [31:0] STACK_LIMIT_DEF = 32'h0000_0800;
  localparam logic [31:0] WORD_BYTES_DEF  = 32'd4;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;
  localparam logic [1:0] ERR_ILL  = 2'd3;

  localparam logic [4:0] SP_REG = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CHK  = 3'd1,
    S_MEM  = 3'd2,
    S_WB   = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // PUSH and CALL both pre-decrement SP and store a word
  function automatic logic is_push(input logic [1:0] op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/stack_addr_calc.sv
// Combinational stack address / next-SP / bounds check. Also used by the
// decoder hazard logic, so it carries no state.
module stack_addr_calc
  import stack_ctrl_pkg::*;
#(
  parameter logic [31:0] STACK_BASE  = STACK_BASE_DEF,
  parameter logic [31:0] STACK_LIMIT = STACK_LIMIT_DEF,
  parameter logic [31:0] WORD_BYTES  = WORD_BYTES_DEF
) (
  input  logic [1:0]  op,
  input  logic [31:0] sp,
  output logic [31:0] addr,
  output logic [31:0] new_sp,
  output logic [1:0]  err
);

  logic [31:0] sp_dec;
  logic [31:0] sp_inc;

  assign sp_dec = sp - WORD_BYTES;
  assign sp_inc = sp + WORD_BYTES;

  always_comb begin
    addr   = sp;
    new_sp = sp_inc;
    err    = ERR_NONE;
    if (is_push(op)) begin
      addr   = sp_dec;
      new_sp = sp_dec;
      // sp < WORD_BYTES catches the decrement wrapping past zero
      if ((sp < WORD_BYTES) || (sp_dec < STACK_LIMIT)) err = ERR_OVF;
    end else if (sp >= STACK_BASE) begin
      err = ERR_UNF;
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// Multi-cycle PUSH/POP/CALL/RET sequencer: IDLE -> CHK -> MEM -> WB, or
// CHK -> ERR on a bounds/illegal-rd fault. Drives regbank and data memory.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter logic [31:0] STACK_BASE  = STACK_BASE_DEF,
  parameter logic [31:0] STACK_LIMIT = STACK_LIMIT_DEF,
  parameter logic [31:0] WORD_BYTES  = WORD_BYTES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [4:0]  reg_sel,
  input  logic [31:0] ret_pc,
  input  logic [31:0] call_target,
  input  logic [31:0] sp_rdata,
  input  logic [31:0] rs_rdata,
  output logic        rb_readSP,
  output logic [4:0]  rb_sr2,
  output logic        rb_writeSP,
  output logic [31:0] rb_write_dataSP,
  output logic        rb_writeReg,
  output logic [4:0]  rb_dr,
  output logic [31:0] rb_write_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_out,
  output logic        pc_load,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code
);

  state_t      state, state_nx;
  logic [1:0]  op_q, err_q;
  logic [4:0]  sel_q;
  logic [31:0] ret_q, tgt_q, addr_q, nsp_q, wdata_q, rdata_q;

  logic [31:0] calc_addr, calc_nsp;
  logic [1:0]  calc_err, chk_err;

  stack_addr_calc #(
    .STACK_BASE (STACK_BASE),
    .STACK_LIMIT(STACK_LIMIT),
    .WORD_BYTES (WORD_BYTES)
  ) u_calc (
    .op    (op_q),
    .sp    (sp_rdata),
    .addr  (calc_addr),
    .new_sp(calc_nsp),
    .err   (calc_err)
  );

  // POP into SP would collide with the SP write-back; decode fault wins
  assign chk_err = ((op_q == OP_POP) && (sel_q == SP_REG)) ? ERR_ILL : calc_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      sel_q   <= '0;
      ret_q   <= '0;
      tgt_q   <= '0;
      addr_q  <= '0;
      nsp_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_q  <= op;
          sel_q <= reg_sel;
          ret_q <= ret_pc;
          tgt_q <= call_target;
        end
        S_CHK: begin
          addr_q  <= calc_addr;
          nsp_q   <= calc_nsp;
          err_q   <= chk_err;
          wdata_q <= (op_q == OP_CALL) ? ret_q : rs_rdata;
        end
        S_MEM: if (mem_ready) rdata_q <= mem_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx        = state;
    rb_readSP       = 1'b0;
    rb_sr2          = '0;
    rb_writeSP      = 1'b0;
    rb_write_dataSP = '0;
    rb_writeReg     = 1'b0;
    rb_dr           = '0;
    rb_write_data   = '0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    pc_out          = '0;
    pc_load         = 1'b0;
    done            = 1'b0;
    err_code        = ERR_NONE;
    busy            = (state != S_IDLE);
    case (state)
      S_IDLE: if (start) state_nx = S_CHK;
      S_CHK: begin
        rb_readSP = 1'b1;
        rb_sr2    = sel_q;
        state_nx  = (chk_err != ERR_NONE) ? S_ERR : S_MEM;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = is_push(op_q);
        mem_addr  = addr_q;
        mem_wdata = is_push(op_q) ? wdata_q : '0;
        if (mem_ready) state_nx = S_WB;
      end
      S_WB: begin
        rb_writeSP      = 1'b1;
        rb_write_dataSP = nsp_q;
        if (op_q == OP_POP) begin
          rb_writeReg   = (sel_q != 5'd0);
          rb_dr         = sel_q;
          rb_write_data = rdata_q;
        end
        if (op_q == OP_CALL) begin
          pc_load = 1'b1;
          pc_out  = tgt_q;
        end else if (op_q == OP_RET) begin
          pc_load = 1'b1;
          pc_out  = rdata_q;
        end
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      S_ERR: begin
        done     = 1'b1;
        err_code = err_q;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: bench-side regbank and wait-state memory, a directed
// vector table, a reset-during-MEM sequence and a randomized run vs. a model.
module tb_stack_ctrl;
  import stack_ctrl_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] LIMIT = 32'h0000_0800;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0]  op = '0;
  logic [4:0]  reg_sel = '0;
  logic [31:0] ret_pc = '0, call_target = '0;
  logic [31:0] sp_rdata, rs_rdata, mem_rdata = '0;
  logic        mem_ready;
  logic        rb_readSP, rb_writeSP, rb_writeReg, mem_req, mem_we, pc_load, busy, done;
  logic [4:0]  rb_sr2, rb_dr;
  logic [31:0] rb_write_dataSP, rb_write_data, mem_addr, mem_wdata, pc_out;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  stack_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .reg_sel(reg_sel),
    .ret_pc(ret_pc), .call_target(call_target), .sp_rdata(sp_rdata), .rs_rdata(rs_rdata),
    .rb_readSP(rb_readSP), .rb_sr2(rb_sr2), .rb_writeSP(rb_writeSP),
    .rb_write_dataSP(rb_write_dataSP), .rb_writeReg(rb_writeReg), .rb_dr(rb_dr),
    .rb_write_data(rb_write_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc_out(pc_out), .pc_load(pc_load), .busy(busy),
    .done(done), .err_code(err_code)
  );

  // environment: register bank (r31 is SP) and data memory with wait states
  bit [31:0] regs [32];
  bit [31:0] mem [bit [31:0]];
  logic        bd_we = 1'b0;
  logic [4:0]  bd_idx = '0;
  logic [31:0] bd_val = '0;
  int mem_waits = 0, wcnt = 0, cyc = 0;
  bit stray_en = 1'b0, stray = 1'b0;

  assign sp_rdata  = rb_readSP ? regs[31] : 32'hBAD0_0001;
  assign rs_rdata  = regs[rb_sr2];
  assign mem_ready = mem_req ? (wcnt >= mem_waits) : stray;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
    if (rb_writeSP)  regs[31]    <= rb_write_dataSP;
    if (rb_writeReg) regs[rb_dr] <= rb_write_data;
    if (bd_we)       regs[bd_idx] <= bd_val;
  end

  always @(posedge clk)
    if (mem_req && mem_we && mem_ready) mem[mem_addr] = mem_wdata;

  always @(negedge clk) begin
    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
    stray     = stray_en && ($urandom_range(0, 1) == 1);
  end

  // reference model state
  bit [31:0] m_regs [32];
  bit [31:0] m_mem [bit [31:0]];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    return m_mem.exists(a) ? m_mem[a] : 32'h0;
  endfunction

  task automatic set_reg(input logic [4:0] idx, input logic [31:0] val);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_idx = idx; bd_val = val;
    @(posedge clk); #1;
    bd_we = 1'b0;
    m_regs[idx] = val;
  endtask

  // observations of one operation
  int o_nreq, o_nwr, o_nregw, o_npc, o_nspw, o_busy_lo, o_ndone, o_lat;
  logic [31:0] o_wa, o_wd, o_rd, o_pc;
  logic [4:0]  o_dr;
  logic [1:0]  o_err;
  logic [1:0]  o_tail;

  task automatic run_op(input logic [1:0] o, input logic [4:0] r, input logic [31:0] rp,
                        input logic [31:0] ct, input int w, input bit poke);
    int t0;
    bit got;
    o_nreq = 0; o_nwr = 0; o_nregw = 0; o_npc = 0; o_nspw = 0; o_busy_lo = 0; o_ndone = 0;
    o_lat = -1; o_wa = 0; o_wd = 0; o_rd = 0; o_pc = 0; o_dr = 0; o_err = 2'bxx;
    @(posedge clk); #1;
    mem_waits = w; op = o; reg_sel = r; ret_pc = rp; call_target = ct; start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; reg_sel = ~r; ret_pc = ~rp; call_target = ~ct;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (poke) start = (k == 0);
      if (mem_req) o_nreq++;
      if (mem_req && mem_ready && mem_we) begin o_nwr++; o_wa = mem_addr; o_wd = mem_wdata; end
      if (rb_writeReg) begin o_nregw++; o_dr = rb_dr; o_rd = rb_write_data; end
      if (pc_load) begin o_npc++; o_pc = pc_out; end
      if (rb_writeSP) o_nspw++;
      if (!busy) o_busy_lo++;
      if (done) begin o_ndone++; o_err = err_code; o_lat = cyc - t0; got = 1'b1; end
    end
    start = 1'b0;
    @(negedge clk);
    o_tail = {done, busy};
  endtask

  task automatic run_check(input logic [1:0] o, input logic [4:0] r, input logic [31:0] rp,
                           input logic [31:0] ct, input int w, input bit poke);
    logic [31:0] sp, e_sp, e_pc, e_wa, e_wd, e_rd;
    logic [1:0]  e_err;
    longint      below;
    bit          pushing;
    int          e_nwr, e_nregw, e_npc;
    sp = m_regs[31];
    pushing = (o == OP_PUSH) || (o == OP_CALL);
    below = longint'(sp) - 64'sd4;
    if (o == OP_POP && r == 5'd31)                 e_err = 2'd3;
    else if (pushing && below < longint'(LIMIT))   e_err = 2'd1;
    else if (!pushing && sp >= BASE)               e_err = 2'd2;
    else                                           e_err = 2'd0;
    e_sp = sp; e_pc = 0; e_wa = 0; e_wd = 0; e_rd = 0; e_nwr = 0; e_nregw = 0; e_npc = 0;
    if (e_err == 2'd0) begin
      case (o)
        OP_PUSH: begin e_wa = sp - 4; e_wd = m_regs[r]; e_sp = sp - 4; e_nwr = 1; end
        OP_CALL: begin e_wa = sp - 4; e_wd = rp; e_sp = sp - 4; e_nwr = 1; e_pc = ct; e_npc = 1; end
        OP_POP:  begin e_rd = m_rd(sp); e_sp = sp + 4; e_nregw = (r != 0) ? 1 : 0; end
        default: begin e_pc = m_rd(sp); e_sp = sp + 4; e_npc = 1; end
      endcase
    end
    run_op(o, r, rp, ct, w, poke);
    chk("done_count", o_ndone, 1);
    chk("err_code", {30'd0, o_err}, {30'd0, e_err});
    chk("latency", o_lat, (e_err != 0) ? 2 : 3 + w);
    chk("mem_req_cycles", o_nreq, (e_err != 0) ? 0 : 1 + w);
    chk("mem_writes", o_nwr, e_nwr);
    if (e_nwr != 0) begin chk("mem_waddr", o_wa, e_wa); chk("mem_wdata", o_wd, e_wd); end
    chk("gpr_writes", o_nregw, e_nregw);
    if (e_nregw != 0) begin chk("gpr_dr", {27'd0, o_dr}, {27'd0, r}); chk("gpr_data", o_rd, e_rd); end
    chk("pc_loads", o_npc, e_npc);
    if (e_npc != 0) chk("pc_out", o_pc, e_pc);
    chk("sp_writes", o_nspw, (e_err != 0) ? 0 : 1);
    chk("sp_value", regs[31], e_sp);
    chk("busy_gaps", o_busy_lo, 0);
    chk("idle_after_done", {30'd0, o_tail}, 32'd0);
    if (e_err == 2'd0) begin
      m_regs[31] = e_sp;
      if (e_nwr != 0) m_mem[e_wa] = e_wd;
      if (e_nregw != 0) m_regs[r] = e_rd;
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ctl"}, {12'd0, rb_readSP, rb_writeSP, rb_writeReg, mem_req, mem_we, pc_load,
                        busy, done, err_code, rb_sr2, rb_dr}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_pc_out"}, pc_out, 32'd0);
    chk({tag, "_sp_wdata"}, rb_write_dataSP, 32'd0);
    chk({tag, "_gpr_wdata"}, rb_write_data, 32'd0);
  endtask

  typedef struct {
    bit          set_sp;
    logic [31:0] sp;
    logic [4:0]  preg;
    logic [31:0] pval;
    logic [1:0]  op;
    logic [4:0]  rsel;
    logic [31:0] rp, ct;
    int          w;
    bit          poke;
    logic [1:0]  x_err;
    int          x_lat;
    logic [31:0] x_sp, x_pc, x_wd, x_gpr;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] corners [12];
    bit seen;
    //          set  sp            preg  pval          op       rsel   rp         ct         w  pk err lat x_sp          x_pc      x_wd          x_gpr
    tbl[0]  = '{1, 32'h0000_1000, 5'd5, 32'hDEAD_BEEF, OP_PUSH, 5'd5,  32'h0,     32'h0,     0, 0, 0, 3, 32'h0000_0FFC, 32'h0,    32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[1]  = '{0, 32'h0,         5'd0, 32'h0,         OP_POP,  5'd7,  32'h0,     32'h0,     2, 0, 0, 5, 32'h0000_1000, 32'h0,    32'h0,         32'hDEAD_BEEF};
    tbl[2]  = '{1, 32'h0000_0800, 5'd0, 32'h0,         OP_PUSH, 5'd1,  32'h0,     32'h0,     0, 0, 1, 2, 32'h0000_0800, 32'h0,    32'h0,         32'h0};
    tbl[3]  = '{1, 32'h0000_1000, 5'd0, 32'h0,         OP_POP,  5'd3,  32'h0,     32'h0,     0, 0, 2, 2, 32'h0000_1000, 32'h0,    32'h0,         32'h0};
    tbl[4]  = '{1, 32'h0000_0FF0, 5'd0, 32'h0,         OP_POP,  5'd31, 32'h0,     32'h0,     0, 0, 3, 2, 32'h0000_0FF0, 32'h0,    32'h0,         32'h0000_0FF0};
    tbl[5]  = '{1, 32'h0000_1000, 5'd0, 32'h0,         OP_CALL, 5'd0,  32'h40,    32'h200,   0, 0, 0, 3, 32'h0000_0FFC, 32'h200,  32'h40,        32'h0};
    tbl[6]  = '{0, 32'h0,         5'd0, 32'h0,         OP_RET,  5'd0,  32'h0,     32'h0,     1, 0, 0, 4, 32'h0000_1000, 32'h40,   32'h0,         32'h0};
    tbl[7]  = '{1, 32'h0000_0FF8, 5'd0, 32'h0,         OP_POP,  5'd0,  32'h0,     32'h0,     0, 0, 0, 3, 32'h0000_0FFC, 32'h0,    32'h0,         32'h0};
    tbl[8]  = '{1, 32'h0000_0804, 5'd0, 32'h0,         OP_PUSH, 5'd31, 32'h0,     32'h0,     0, 0, 0, 3, 32'h0000_0800, 32'h0,    32'h0000_0804, 32'h0000_0800};
    tbl[9]  = '{1, 32'h0000_0002, 5'd0, 32'h0,         OP_PUSH, 5'd1,  32'h0,     32'h0,     0, 0, 1, 2, 32'h0000_0002, 32'h0,    32'h0,         32'h0};
    tbl[10] = '{1, 32'h0000_0FFC, 5'd0, 32'h0,         OP_POP,  5'd9,  32'h0,     32'h0,     1, 1, 0, 4, 32'h0000_1000, 32'h0,    32'h0,         32'h40};
    tbl[11] = '{1, 32'hFFFF_FFFC, 5'd0, 32'h0,         OP_POP,  5'd2,  32'h0,     32'h0,     0, 0, 2, 2, 32'hFFFF_FFFC, 32'h0,    32'h0,         32'h0};
    tbl[12] = '{1, 32'h0000_0000, 5'd0, 32'h0,         OP_CALL, 5'd0,  32'h44,    32'h300,   0, 1, 1, 2, 32'h0000_0000, 32'h0,    32'h0,         32'h0};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_outs_zero("reset");
    @(negedge clk) reset = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].set_sp) set_reg(5'd31, tbl[i].sp);
      if (tbl[i].preg != 5'd0) set_reg(tbl[i].preg, tbl[i].pval);
      run_check(tbl[i].op, tbl[i].rsel, tbl[i].rp, tbl[i].ct, tbl[i].w, tbl[i].poke);
      chk($sformatf("tbl%0d_err", i), {30'd0, o_err}, {30'd0, tbl[i].x_err});
      chk($sformatf("tbl%0d_lat", i), o_lat, tbl[i].x_lat);
      chk($sformatf("tbl%0d_sp", i), regs[31], tbl[i].x_sp);
      chk($sformatf("tbl%0d_pc", i), o_pc, tbl[i].x_pc);
      chk($sformatf("tbl%0d_wdata", i), o_wd, tbl[i].x_wd);
      chk($sformatf("tbl%0d_gpr", i), regs[tbl[i].rsel], tbl[i].x_gpr);
    end

    // reset while a PUSH sits in MEM waiting on a memory that never answers
    set_reg(5'd31, 32'h0000_1000);
    set_reg(5'd5, 32'h1234_5678);
    @(posedge clk); #1;
    mem_waits = 1000; op = OP_PUSH; reg_sel = 5'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    chk("rst_mid_reached_mem", {31'd0, seen}, 32'd1);
    #2 reset = 1'b1;
    #1 chk_outs_zero("rst_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; mem_waits = 0;
    chk("rst_mid_sp_kept", regs[31], 32'h0000_1000);
    chk("rst_mid_mem_kept", mem.exists(32'h0FFC) ? mem[32'h0FFC] : 32'h0, m_rd(32'h0FFC));
    run_check(OP_PUSH, 5'd5, 32'h0, 32'h0, 0, 0);
    chk("rst_after_push_data", o_wd, 32'h1234_5678);

    // randomized ops against the model, with stray mem_ready outside MEM
    corners = '{32'h800, 32'h804, 32'h808, 32'h1000, 32'hFFC, 32'hFF8,
                32'h0, 32'h4, 32'h2, 32'hFFFF_FFFC, 32'hC00, 32'h900};
    stray_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int pick;
      logic [4:0] r;
      pick = $urandom_range(0, 9);
      if (pick == 0)      set_reg(5'd31, corners[$urandom_range(0, 11)]);
      else if (pick == 1) set_reg(5'($urandom_range(1, 30)), $urandom);
      r = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      run_check(2'($urandom_range(0, 3)), r, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end
    stray_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
